// File: rtl/srv_pkg.sv
// Shared definitions for the sr_cpu data-side store path.
// Holds the store-buffer entry type, the drain FSM encoding and MMIO addresses.
// No logic; imported by the store buffer and by the MMIO decode behind it.
package srv_pkg;

  localparam int XLEN = 32;

  // Drain FSM: IDLE = nothing on the wire, BUSY = head entry presented to target
  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sb_state_t;

  // Cycle-counter control registers decoded downstream of the store buffer
  localparam logic [XLEN-1:0] CNT_EN_ADDR  = 32'h200;
  localparam logic [XLEN-1:0] CNT_CLR_ADDR = 32'h201;

  // One posted store
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/srv_sb_fifo.sv
// Circular entry storage for the store buffer with head, head+1 and tail-1 ports.
// Latency: push/pop/overwrite take effect at the clock edge; read ports are combinational.
// No internal backpressure: the caller must not push when full or pop when empty.
module srv_sb_fifo
  import srv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  sb_entry_t              push_ent,
  input  logic                   pop,
  input  logic                   ovw,
  input  logic [XLEN-1:0]        ovw_data,
  output sb_entry_t              head_ent,
  output sb_entry_t              next_ent,
  output logic [XLEN-1:0]        tail_addr,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   PTR_ONE = 1;
  localparam logic [PW-1:0] IDX_ONE = 1;

  sb_entry_t     mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;
  logic [PW-1:0] tail_idx;
  logic [PW-1:0] next_idx;

  // Index arithmetic wraps naturally modulo DEPTH (power of two)
  assign wr_idx   = wr_ptr[PW-1:0];
  assign rd_idx   = rd_ptr[PW-1:0];
  assign tail_idx = wr_idx - IDX_ONE;
  assign next_idx = rd_idx + IDX_ONE;

  // Pointers carry an extra MSB so full (DEPTH apart) and empty (equal) differ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage: append at the tail, or merge new data into the youngest entry
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx]      <= push_ent;
    if (ovw)  mem[tail_idx].data <= ovw_data;
  end

  assign head_ent  = mem[rd_idx];
  assign next_ent  = mem[next_idx];
  assign tail_addr = mem[tail_idx].addr;
  assign level     = wr_ptr - rd_ptr;

endmodule

// File: rtl/srv_store_buf.sv
// Posted-write store buffer between the sr_cpu store port and a slow req/ack target.
// Latency: store absorbed at edge N, ext_req_o rises after N+1; up to one write per cycle.
// Backpressure: cpu_stall_o while DEPTH entries are held; target stalls via ext_ack_i.
module srv_store_buf
  import srv_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter bit COALESCE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_we_i,
  input  logic [XLEN-1:0]        cpu_addr_i,
  input  logic [XLEN-1:0]        cpu_data_i,
  output logic                   cpu_stall_o,
  output logic                   ext_req_o,
  output logic [XLEN-1:0]        ext_addr_o,
  output logic [XLEN-1:0]        ext_data_o,
  input  logic                   ext_ack_i,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = 1;
  localparam logic [LW-1:0] LVL_TWO  = 2;

  sb_state_t       state;
  sb_state_t       state_nxt;
  sb_entry_t       ext_q;
  sb_entry_t       ext_d;
  sb_entry_t       head_ent;
  sb_entry_t       next_ent;
  sb_entry_t       push_ent;
  logic [XLEN-1:0] tail_addr;
  logic [LW-1:0]   level;
  logic            full;
  logic            pop;
  logic            push;
  logic            coal;
  logic            tail_locked;

  assign full = (level == LVL_FULL);
  assign pop  = (state == SB_BUSY) && ext_ack_i;

  // The youngest entry is off limits for merging when it is already on the wire
  // (only entry) or is the one being loaded onto the wire at this edge (second
  // entry while the head is acked). Merging then would lose the new data.
  assign tail_locked = (level == LVL_ONE) || (pop && (level == LVL_TWO));

  // Merge is allowed even when full, so a stalled CPU retrying the same word
  // simply rewrites it.
  assign coal = COALESCE && cpu_we_i && (level != '0) &&
                (tail_addr == cpu_addr_i) && !tail_locked;
  assign push = cpu_we_i && !full && !coal;

  assign push_ent.addr = cpu_addr_i;
  assign push_ent.data = cpu_data_i;

  srv_sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_ent  (push_ent),
    .pop       (pop),
    .ovw       (coal),
    .ovw_data  (cpu_data_i),
    .head_ent  (head_ent),
    .next_ent  (next_ent),
    .tail_addr (tail_addr),
    .level     (level)
  );

  // Drain FSM next state: present head, then on ack chain straight to the next entry
  always_comb begin
    state_nxt = state;
    ext_d     = ext_q;
    case (state)
      SB_IDLE: begin
        if (level != '0) begin
          state_nxt = SB_BUSY;
          ext_d     = head_ent;
        end
      end
      SB_BUSY: begin
        if (ext_ack_i) begin
          if (level > LVL_ONE) begin
            ext_d = next_ent;
          end else begin
            state_nxt = SB_IDLE;
          end
        end
      end
      default: state_nxt = SB_IDLE;
    endcase
  end

  // Drain FSM state and the registered request payload; reset drops any pending ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SB_IDLE;
      ext_q <= '0;
    end else begin
      state <= state_nxt;
      ext_q <= ext_d;
    end
  end

  assign ext_req_o   = (state == SB_BUSY);
  assign ext_addr_o  = ext_q.addr;
  assign ext_data_o  = ext_q.data;
  assign cpu_stall_o = full;
  assign empty_o     = (level == '0);
  assign level_o     = level;

endmodule

// File: tb/tb_srv_store_buf.sv
// Self-checking bench for srv_store_buf: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the posted-write buffer.
// Target writes are logged from the DUT handshake and checked for order/content.
module tb_srv_store_buf;
  import srv_pkg::*;

  localparam int DEPTH    = 4;
  localparam bit COALESCE = 1'b1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_stall_o;
  logic        ext_req_o;
  logic [31:0] ext_addr_o;
  logic [31:0] ext_data_o;
  logic        ext_ack_i;
  logic        empty_o;
  logic [$clog2(DEPTH):0] level_o;

  int total = 0;
  int bad   = 0;

  // Reference model: pending stores in program order, head first
  ent_t mq[$];
  bit   m_infl;
  ent_t exp_log[$];
  ent_t tgt_log[$];

  srv_store_buf #(
    .DEPTH    (DEPTH),
    .COALESCE (COALESCE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_stall_o (cpu_stall_o),
    .ext_req_o   (ext_req_o),
    .ext_addr_o  (ext_addr_o),
    .ext_data_o  (ext_data_o),
    .ext_ack_i   (ext_ack_i),
    .empty_o     (empty_o),
    .level_o     (level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance model
  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d, input bit ack);
    int   lvl;
    bit   pop;
    bit   locked;
    bit   coal;
    bit   push;
    ent_t e;
    lvl = mq.size();
    chk("level", 32'(level_o), lvl);
    chk("stall", 32'(cpu_stall_o), 32'(lvl == DEPTH));
    chk("empty", 32'(empty_o), 32'(lvl == 0));
    chk("req", 32'(ext_req_o), 32'(m_infl));
    if (m_infl) begin
      chk("ext_addr", ext_addr_o, mq[0].a);
      chk("ext_data", ext_data_o, mq[0].d);
    end
    cpu_we_i   = we;
    cpu_addr_i = a;
    cpu_data_i = d;
    ext_ack_i  = ack;
    if (ext_req_o && ack) begin
      e.a = ext_addr_o;
      e.d = ext_data_o;
      tgt_log.push_back(e);
    end
    pop = m_infl && ack;
    // Youngest entry is on the wire, or becomes the wire payload at this edge
    locked = (lvl - 1) <= int'(pop);
    coal = COALESCE && we && (lvl > 0) && !locked && (mq[lvl-1].a == a);
    push = we && (lvl < DEPTH) && !coal;
    if (coal) mq[lvl-1].d = d;
    if (pop) exp_log.push_back(mq.pop_front());
    if (push) begin
      e.a = a;
      e.d = d;
      mq.push_back(e);
    end
    if (m_infl) m_infl = pop ? (lvl > 1) : 1'b1;
    else        m_infl = (lvl > 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!empty_o && n < 30) begin
      step(1'b0, 32'h0, 32'h0, 1'b1);
      n++;
    end
    chk({tag, "_drained"}, 32'(empty_o), 32'd1);
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < tgt_log.size()) begin
      chk({tag, "_addr"}, tgt_log[idx].a, a);
      chk({tag, "_data"}, tgt_log[idx].d, d);
    end else begin
      chk({tag, "_missing"}, 32'(tgt_log.size()), 32'(idx + 1));
    end
  endtask

  task automatic clear_logs();
    tgt_log.delete();
    exp_log.delete();
  endtask

  initial begin
    bit          acc;
    logic [31:0] ra;
    rst_n      = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    ext_ack_i  = 1'b0;
    m_infl     = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_stall", 32'(cpu_stall_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_req", 32'(ext_req_o), 32'd0);
    chk("rst_addr", ext_addr_o, 32'd0);
    chk("rst_data", ext_data_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single store, ack tied high: request one cycle after the push
    clear_logs();
    step(1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
    chk("t1_req_early", 32'(ext_req_o), 32'd0);
    chk("t1_empty_mid", 32'(empty_o), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("t1_req", 32'(ext_req_o), 32'd1);
    chk("t1_addr", ext_addr_o, 32'h100);
    chk("t1_data", ext_data_o, 32'hDEADBEEF);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("t1_empty", 32'(empty_o), 32'd1);
    chk("t1_req_drop", 32'(ext_req_o), 32'd0);
    chk_log("t1_w0", 0, 32'h100, 32'hDEADBEEF);

    // Fill to full with ack low, fifth store held, then released in order
    clear_logs();
    for (int i = 1; i <= 4; i++) step(1'b1, 32'h10 * i, i, 1'b0);
    chk("t2_level_full", 32'(level_o), 32'd4);
    chk("t2_stall", 32'(cpu_stall_o), 32'd1);
    step(1'b1, 32'h50, 32'd5, 1'b0);
    chk("t2_level_held", 32'(level_o), 32'd4);
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) begin
      acc = !cpu_stall_o;
      step(1'b1, 32'h50, 32'd5, 1'b1);
    end
    chk("t2_accept", 32'(acc), 32'd1);
    wait_empty("t2");
    chk("t2_count", 32'(tgt_log.size()), 32'd5);
    for (int i = 1; i <= 5; i++) chk_log("t2_w", i - 1, 32'h10 * i, i);

    // Coalesce into youngest non-head entry
    clear_logs();
    step(1'b1, CNT_EN_ADDR, 32'd1, 1'b0);
    step(1'b1, 32'h300, 32'd2, 1'b0);
    step(1'b1, 32'h300, 32'd7, 1'b0);
    chk("t3_level", 32'(level_o), 32'd2);
    wait_empty("t3");
    chk("t3_count", 32'(tgt_log.size()), 32'd2);
    chk_log("t3_w0", 0, 32'h200, 32'd1);
    chk_log("t3_w1", 1, 32'h300, 32'd7);

    // Same address as in-flight head appends instead of merging
    clear_logs();
    step(1'b1, 32'h200, 32'd1, 1'b0);
    step(1'b1, 32'h200, 32'd0, 1'b0);
    chk("t4_level", 32'(level_o), 32'd2);
    wait_empty("t4");
    chk("t4_count", 32'(tgt_log.size()), 32'd2);
    chk_log("t4_w0", 0, 32'h200, 32'd1);
    chk_log("t4_w1", 1, 32'h200, 32'd0);

    // Full buffer with ack: still stalls that cycle, then push+pop keeps level
    clear_logs();
    for (int i = 1; i <= 4; i++) step(1'b1, 32'h400 + i, 32'hA0 + i, 1'b0);
    chk("t5_full", 32'(level_o), 32'd4);
    step(1'b1, 32'h500, 32'hB0, 1'b1);
    chk("t5_level_a", 32'(level_o), 32'd3);
    chk("t5_req_a", 32'(ext_req_o), 32'd1);
    chk("t5_addr_a", ext_addr_o, 32'h402);
    step(1'b1, 32'h500, 32'hB0, 1'b1);
    chk("t5_level_b", 32'(level_o), 32'd3);
    chk("t5_req_b", 32'(ext_req_o), 32'd1);
    chk("t5_addr_b", ext_addr_o, 32'h403);
    wait_empty("t5");
    chk("t5_count", 32'(tgt_log.size()), 32'd5);
    for (int i = 1; i <= 4; i++) chk_log("t5_w", i - 1, 32'h400 + i, 32'hA0 + i);
    chk_log("t5_w4", 4, 32'h500, 32'hB0);

    // Asynchronous reset while BUSY with three entries
    clear_logs();
    for (int i = 1; i <= 3; i++) step(1'b1, 32'h600 + i, i, 1'b0);
    chk("t6_level_pre", 32'(level_o), 32'd3);
    cpu_we_i  = 1'b0;
    ext_ack_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", 32'(ext_req_o), 32'd0);
    chk("t6_level", 32'(level_o), 32'd0);
    chk("t6_empty", 32'(empty_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_infl = 1'b0;
    clear_logs();
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("t6_no_writes", 32'(tgt_log.size()), 32'd0);

    // Random traffic against the model
    clear_logs();
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(3))
        0:       ra = CNT_EN_ADDR;
        1:       ra = CNT_CLR_ADDR;
        2:       ra = 32'h204;
        default: ra = 32'h300;
      endcase
      step($urandom_range(99) < 60, ra, $urandom, 1'($urandom_range(1)));
    end
    wait_empty("rnd");
    chk("rnd_count", 32'(tgt_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < tgt_log.size(); i++) begin
      chk("rnd_addr", tgt_log[i].a, exp_log[i].a);
      chk("rnd_data", tgt_log[i].d, exp_log[i].d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
